// File: rtl/ddr3_avl_arbiter.sv
// Arbitrates a burst-write capture port and a burst-read consumer port onto one Avalon-MM DDR3 controller.
// Optional macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of write always winning.
module ddr3_avl_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int SIZE_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [SIZE_W-1:0]   wr_size,
    input  logic [DATA_W-1:0]   wr_wdata,
    output logic                wr_wready,
    output logic                wr_done,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [SIZE_W-1:0]   rd_size,
    output logic [DATA_W-1:0]   rd_rdata,
    output logic                rd_rdata_valid,
    output logic                rd_done,
    input  logic                avl_waitrequest,
    output logic [ADDR_W-1:0]   avl_addr,
    output logic [SIZE_W-1:0]   avl_size,
    output logic [DATA_W-1:0]   avl_wdata,
    output logic [DATA_W/8-1:0] avl_be,
    output logic                avl_write_req,
    output logic                avl_read_req,
    input  logic [DATA_W-1:0]   avl_rdata,
    input  logic                avl_rdata_valid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_WAIT  = 2'd3
    } state_t;

    localparam logic [SIZE_W-1:0] CNT_ONE = {{(SIZE_W-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [SIZE_W-1:0]   r_size, w_size_nxt;
    logic [SIZE_W-1:0]   r_cnt, w_cnt_nxt;
    logic                r_wr_done, w_wr_done_nxt;
    logic                r_rd_done, w_rd_done_nxt;
    logic                w_wr_pend, w_rd_pend, w_grant_wr, w_last_beat;

    // Zero-length requests are never granted; they only earn a done pulse.
    assign w_wr_pend   = wr_req && (wr_size != '0);
    assign w_rd_pend   = rd_req && (rd_size != '0);
    assign w_last_beat = (r_cnt == (r_size - CNT_ONE));

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_wr;

    assign w_grant_wr = w_wr_pend && (!w_rd_pend || !r_last_wr);

    // Remembers which side won the most recent grant; resets to "read" so the first tie goes to write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_wr <= 1'b0;
        end else if ((r_state == IDLE) && (w_wr_pend || w_rd_pend)) begin
            r_last_wr <= w_grant_wr;
        end else begin
            r_last_wr <= r_last_wr;
        end
    end
`else
    assign w_grant_wr = w_wr_pend;
`endif

    // State and burst bookkeeping registers; reset aborts a burst without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_size    <= '0;
            r_cnt     <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_size    <= w_size_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_rd_done <= w_rd_done_nxt;
        end
    end

    // Next-state logic and state-qualified Avalon / requester outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_size_nxt     = r_size;
        w_cnt_nxt      = r_cnt;
        w_wr_done_nxt  = 1'b0;
        w_rd_done_nxt  = 1'b0;
        avl_write_req  = 1'b0;
        avl_read_req   = 1'b0;
        avl_wdata      = '0;
        avl_be         = '0;
        wr_wready      = 1'b0;
        rd_rdata       = '0;
        rd_rdata_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt     = '0;
                w_wr_done_nxt = wr_req && (wr_size == '0);
                w_rd_done_nxt = rd_req && (rd_size == '0);
                if (w_grant_wr) begin
                    w_addr_nxt  = wr_addr;
                    w_size_nxt  = wr_size;
                    w_state_nxt = WR_BURST;
                end else if (w_rd_pend) begin
                    w_addr_nxt  = rd_addr;
                    w_size_nxt  = rd_size;
                    w_state_nxt = RD_CMD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WR_BURST: begin
                avl_write_req = 1'b1;
                avl_wdata     = wr_wdata;
                avl_be        = '1;
                wr_wready     = !avl_waitrequest;
                if (!avl_waitrequest && w_last_beat) begin
                    w_state_nxt   = IDLE;
                    w_wr_done_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else if (!avl_waitrequest) begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            RD_CMD, RD_WAIT: begin
                avl_read_req   = (r_state == RD_CMD);
                rd_rdata       = avl_rdata;
                rd_rdata_valid = avl_rdata_valid;
                // Data may overtake command acceptance, so beats count in both read states.
                if (avl_rdata_valid && w_last_beat) begin
                    w_state_nxt   = IDLE;
                    w_rd_done_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = avl_rdata_valid ? (r_cnt + CNT_ONE) : r_cnt;
                    if ((r_state == RD_CMD) && !avl_waitrequest) begin
                        w_state_nxt = RD_WAIT;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign avl_addr = r_addr;
    assign avl_size = r_size;
    assign wr_done  = r_wr_done;
    assign rd_done  = r_rd_done;

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Randomized self-checking bench for ddr3_avl_arbiter: requester and Avalon slave behaviour modelled per transaction.
module tb_ddr3_avl_arbiter;

    logic         clk, rst;
    logic         wr_req, wr_wready, wr_done;
    logic [31:0]  wr_addr;
    logic [9:0]   wr_size;
    logic [127:0] wr_wdata;
    logic         rd_req, rd_rdata_valid, rd_done;
    logic [31:0]  rd_addr;
    logic [9:0]   rd_size;
    logic [127:0] rd_rdata;
    logic         avl_waitrequest, avl_write_req, avl_read_req, avl_rdata_valid;
    logic [31:0]  avl_addr;
    logic [9:0]   avl_size;
    logic [127:0] avl_wdata, avl_rdata;
    logic [15:0]  avl_be;

    int n_cmp = 0;
    int n_mis = 0;

    ddr3_avl_arbiter dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_wdata(wr_wdata),
        .wr_wready(wr_wready), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_rdata(rd_rdata),
        .rd_rdata_valid(rd_rdata_valid), .rd_done(rd_done),
        .avl_waitrequest(avl_waitrequest), .avl_addr(avl_addr), .avl_size(avl_size),
        .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_write_req(avl_write_req),
        .avl_read_req(avl_read_req), .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] beat_data(input logic [31:0] a, input int k);
        return {a, 32'(k), ~a, 32'h5A5A_0000 ^ 32'(k)};
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wreq"}, avl_write_req, 1'b0);
        check_eq({tag, "_rreq"}, avl_read_req, 1'b0);
        check_eq({tag, "_wready"}, wr_wready, 1'b0);
        check_eq({tag, "_wdone"}, wr_done, 1'b0);
        check_eq({tag, "_rdone"}, rd_done, 1'b0);
        check_eq({tag, "_rvalid"}, rd_rdata_valid, 1'b0);
        check_eq({tag, "_addr"}, avl_addr, 32'd0);
        check_eq({tag, "_size"}, avl_size, 10'd0);
        check_eq({tag, "_be"}, avl_be, 16'd0);
        check_eq({tag, "_wdata"}, avl_wdata, 128'd0);
        check_eq({tag, "_rdata"}, rd_rdata, 128'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        avl_waitrequest = 1'b0;
        avl_rdata_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // One write transaction: the requester holds req until done, the slave stalls randomly or as forced.
    task automatic do_write(input logic [31:0] a, input logic [9:0] n, input int pct,
                            input int stall_beat, input int stall_len, output int act_cyc);
        int k, cyc, stalls;
        bit last_acc, fin, wt, active;
        k = 0; cyc = 0; stalls = 0; last_acc = 1'b0; fin = 1'b0; act_cyc = 0;
        wr_req = 1'b1; wr_addr = a; wr_size = n;
        while (!fin && cyc < 300) begin
            check_eq("wr_done", wr_done, last_acc);
            check_eq("rd_done_quiet", rd_done, 1'b0);
            if (last_acc) begin
                fin = 1'b1;
                wr_req = 1'b0;
            end
            if (k == stall_beat && stalls < stall_len) begin
                wt = 1'b1;
                stalls++;
            end else begin
                wt = ($urandom_range(99) < pct);
            end
            avl_waitrequest = wt;
            wr_wdata = beat_data(a, k);
            avl_rdata_valid = 1'($urandom_range(1));
            avl_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            active = (cyc >= 1) && !fin && (n != 10'd0);
            check_eq("wr_req_out", avl_write_req, active);
            check_eq("wr_wready", wr_wready, active && !wt);
            check_eq("wr_rreq_quiet", avl_read_req, 1'b0);
            check_eq("wr_rvalid_gated", rd_rdata_valid, 1'b0);
            check_eq("wr_be", avl_be, active ? 16'hFFFF : 16'h0000);
            if (active) begin
                check_eq("wr_addr", avl_addr, a);
                check_eq("wr_size", avl_size, n);
                check_eq("wr_wdata", avl_wdata, beat_data(a, k));
                act_cyc++;
                if (!wt) begin
                    k++;
                    last_acc = (k == int'(n));
                end
            end
            if (cyc == 0 && n == 10'd0) last_acc = 1'b1;
            cyc++;
            step();
        end
        check_eq("wr_finished", fin, 1'b1);
        check_eq("wr_beats", k, n);
        wr_req = 1'b0;
        avl_waitrequest = 1'b0;
        avl_rdata_valid = 1'b0;
    endtask

    // One read transaction: slave accepts the command after stalls, then returns n beats with random gaps.
    task automatic do_read(input logic [31:0] a, input logic [9:0] n, input int wpct,
                           input int force_wait, input int vpct, output int cmd_cyc);
        int beats, cyc, waits;
        bit acc, last_beat, fin, wt, vl, cmd_exp, in_rd;
        logic [127:0] d;
        beats = 0; cyc = 0; waits = 0; acc = 1'b0; last_beat = 1'b0; fin = 1'b0; cmd_cyc = 0;
        rd_req = 1'b1; rd_addr = a; rd_size = n;
        while (!fin && cyc < 300) begin
            check_eq("rd_done", rd_done, last_beat);
            check_eq("wr_done_quiet", wr_done, 1'b0);
            if (last_beat) begin
                fin = 1'b1;
                rd_req = 1'b0;
            end
            in_rd = (cyc >= 1) && !fin && (n != 10'd0);
            cmd_exp = in_rd && !acc;
            if (cmd_exp && waits < force_wait) begin
                wt = 1'b1;
                waits++;
            end else begin
                wt = ($urandom_range(99) < wpct);
            end
            if (in_rd && acc) vl = (beats < int'(n)) && ($urandom_range(99) < vpct);
            else if (!in_rd) vl = 1'($urandom_range(1));
            else vl = 1'b0;
            d = {$urandom, $urandom, $urandom, $urandom};
            avl_waitrequest = wt;
            avl_rdata_valid = vl;
            avl_rdata = d;
            #1;
            check_eq("rd_req_out", avl_read_req, cmd_exp);
            check_eq("rd_wreq_quiet", avl_write_req, 1'b0);
            check_eq("rd_be", avl_be, 16'h0000);
            check_eq("rd_valid", rd_rdata_valid, in_rd && vl);
            if (in_rd && vl) check_eq("rd_rdata", rd_rdata, d);
            if (cmd_exp) begin
                check_eq("rd_addr", avl_addr, a);
                check_eq("rd_size", avl_size, n);
                cmd_cyc++;
                if (!wt) acc = 1'b1;
            end
            if (in_rd && vl) begin
                beats++;
                last_beat = (beats == int'(n));
            end
            if (cyc == 0 && n == 10'd0) last_beat = 1'b1;
            cyc++;
            step();
        end
        check_eq("rd_finished", fin, 1'b1);
        check_eq("rd_beats", beats, n);
        rd_req = 1'b0;
        avl_waitrequest = 1'b0;
        avl_rdata_valid = 1'b0;
    endtask

    initial begin
        int c, g;
        bit exp_w;
        logic [9:0] sz;
        wr_addr = 32'd0; wr_size = 10'd0; wr_wdata = 128'd0;
        rd_addr = 32'd0; rd_size = 10'd0; avl_rdata = 128'd0;
        do_reset();
        check_all_zero("reset");

        do_write(32'h100, 10'd4, 0, 0, 0, c);
        check_eq("w4_cycles", c, 4);
        do_write(32'h200, 10'd3, 0, 1, 2, c);
        check_eq("w3_stall_cycles", c, 5);
        do_read(32'h300, 10'd2, 0, 3, 100, c);
        check_eq("r2_cmd_cycles", c, 4);
        do_write(32'h400, 10'd0, 0, 0, 0, c);
        check_eq("w0_cycles", c, 0);
        do_read(32'h500, 10'd0, 0, 0, 100, c);
        check_eq("r0_cycles", c, 0);

        // Reset lands while beat 2 of an 8-beat write is on the bus.
        wr_req = 1'b1; wr_addr = 32'h600; wr_size = 10'd8;
        wr_wdata = 128'hDEAD_BEEF; avl_rdata = 128'hFACE;
        step();
        check_eq("mid_beat1", avl_write_req, 1'b1);
        step();
        check_eq("mid_beat2", avl_write_req, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_req = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("midrst_no_done", wr_done, 1'b0);
        end
        step();
        do_write(32'h600, 10'd3, 0, 0, 0, c);
        check_eq("restart_cycles", c, 3);

        // Both requesters hold size-1 requests continuously.
        do_reset();
        wr_req = 1'b1; rd_req = 1'b1; wr_size = 10'd1; rd_size = 10'd1;
        wr_addr = 32'h700; rd_addr = 32'h800;
        avl_waitrequest = 1'b0; avl_rdata_valid = 1'b1;
        g = 0;
        for (int cy = 0; cy < 40 && g < 6; cy++) begin
            #1;
            if (avl_write_req || avl_read_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_w = ((g % 2) == 0);
`else
                exp_w = 1'b1;
`endif
                check_eq("tie_grant", avl_write_req, exp_w);
                g++;
            end
            step();
        end
        check_eq("tie_grant_count", g, 6);
        do_reset();

        for (int t = 0; t < 40; t++) begin
            sz = ($urandom_range(9) == 0) ? 10'd0 : 10'($urandom_range(8, 1));
            if ($urandom_range(1) == 1) do_write($urandom, sz, $urandom_range(60), 0, 0, c);
            else do_read($urandom, sz, $urandom_range(60), 0, $urandom_range(100, 30), c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
